// File: rtl/uart_tx_console.sv
// Memory-mapped 8N1 UART transmit console: byte FIFO fed by core stores, serialised on tx.
// Optional `UART_TX_SIM_PRINT_EN echoes each accepted byte to the simulation console.
module uart_tx_console #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_sel,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty, overflow;
  logic          hit_txdata, hit_status, push_req, push, pop, ovf_clr;
  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic          baud_last;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shreg, shreg_next;
  logic          tx_q, tx_next;
  logic          unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  assign bus_sel    = (bus_addr[31:3] == BASE_ADDR[31:3]);
  assign hit_txdata = bus_sel && (bus_addr[2:0] == 3'd0);
  assign hit_status = bus_sel && (bus_addr[2:0] == 3'd4);

  // Full uses the pre-edge flag, so a push against a full FIFO drops even if a pop coincides.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req   = bus_we && hit_txdata;
  assign push       = push_req && !fifo_full;
  assign ovf_clr    = bus_we && hit_status && bus_wdata[2];

  assign tx_busy   = (state != IDLE) || !fifo_empty;
  assign bus_rdata = (bus_re && hit_status) ? {29'd0, overflow, tx_busy, fifo_full} : 32'd0;
  assign tx        = tx_q;
  assign baud_last = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    tx_next    = tx_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = mem[rd_ptr[AW-1:0]];
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
          tx_next    = shreg[0];
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_idx + 3'd1;
            tx_next  = shreg[bit_idx + 3'd1];
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          // Chain straight into the next start bit so frames run back to back.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shreg_next = mem[rd_ptr[AW-1:0]];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      tx_q     <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      tx_q     <= tx_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;
`ifdef UART_TX_SIM_PRINT_EN
      if (push) $write("%c", bus_wdata[7:0]);
`endif
    end
  end

  // Datapath storage carries no reset; pointers and FSM state decide validity.
  always_ff @(posedge clk) begin
    shreg <= shreg_next;
    if (push) mem[wr_ptr[AW-1:0]] <= bus_wdata[7:0];
  end

endmodule

// File: doc/uart_tx_console.md
# uart_tx_console

Memory-mapped UART transmit console that sits directly downstream of the RISC-V core on its data-memory bus. It receives the core's stores to a fixed address window and buffers the bytes in a small FIFO. It then serialises them as 8N1 frames on a single `tx` line, which is how the program's text output (e.g. "Hello World") leaves the CPU. Status is readable so firmware can poll for space before writing.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000, word-aligned base of the 8-byte register window.
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be ≥2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- bus_addr  in  32  core data address.
- bus_we  in  1  store strobe, one cycle per store.
- bus_re  in  1  load strobe.
- bus_wdata  in  32  store data; only [7:0] used for TXDATA, [2] for STATUS clear.
- bus_rdata  out  32  combinational read data; 0 when not selected.
- bus_sel  out  1  high when bus_addr is inside the window; the core uses it to mux rdata.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Register map:
  - TXDATA at BASE_ADDR+0, write-only. A write pushes bus_wdata[7:0]. Reads return 0.
  - STATUS at BASE_ADDR+4. Read bit0 = fifo_full, bit1 = tx_busy, bit2 = overflow (sticky), other bits 0. Writing 1 to bit2 clears overflow; all other write bits are ignored.
- Other addresses inside the window read 0 and ignore writes.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits with natural wrap; full and empty are derived from the MSB compare.
  - A push when full is judged on the pre-edge flag. Such a push is dropped and sets overflow, even if a pop occurs on the same edge.
  - A push to an empty FIFO while the FSM is idle is accepted normally.
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out 8 bits LSB first, CLKS_PER_BIT cycles each. A 3-bit index counts 0..7, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last cycle, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, clear on every state entry, width $clog2(CLKS_PER_BIT).
- tx is driven from a register (glitch-free).
- Reset values:
  - tx=1, tx_busy=0, bus_rdata=0 (selects nothing).
  - FIFO empty, overflow=0, FSM IDLE, all counters 0.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). Buffered bytes are discarded.

## Timing
- A store accepted at edge N is in the FIFO after N.
- The FSM pops at N+1; tx falls after N+1, i.e. one cycle of latency from the store edge to the start bit.
- One frame = 10·CLKS_PER_BIT cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- tx_busy rises after the push edge N and falls after the last stop-bit cycle when the FIFO is empty.
- STATUS reads are combinational, so a read in the same cycle as a push sees pre-edge flags.
- A simultaneous push and pop with the FIFO not full leaves the count unchanged.

## Configuration
- `UART_TX_SIM_PRINT_EN`:
  - Defined: each accepted TXDATA push also executes `$write("%c", byte)` at the push edge, so the simulation console shows program output without decoding `tx`. Dropped (overflow) bytes print nothing.
  - Undefined: no system tasks and fully synthesizable. Functional behaviour is identical either way.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset, then idle 20 cycles → tx=1, tx_busy=0, STATUS read = 0x0.
- Store 0x48 to TXDATA at edge N → tx low from N+1 for 4 cycles, then data bits 0,0,0,1,0,0,1,0 (4 cycles each), then high 4 cycles. tx_busy falls 41 cycles after N.
- Store 'H','i' on consecutive cycles → two frames with no gap between stop and start; total busy = 81 cycles.
- Store 6 bytes in 6 consecutive cycles while the first frame is active:
  - Expected: bytes 1–5 are transmitted (the first is popped to the shifter, then 4 are buffered), byte 6 is dropped.
  - STATUS = 0x7 while full; after writing 0x4 to STATUS, bit2 = 0.
- Assert rst mid-DATA with 3 bytes queued → tx=1 the same cycle, and after release no frames are sent.
- Build with `UART_TX_SIM_PRINT_EN`, store "Hello World\n" with polling on bit0 → console prints "Hello World", and the decoded tx stream matches.
